fifo_stream_reader: RTL and testbench

Read-side drain controller for the team's synchronous FIFO. It watches the FIFO empty flag, issues FIFO read enables, and captures the returned words into a small local skid buffer. It presents those words downstream on a valid/ready stream, so consumers never deal with FIFO read latency. It sits between the FIFO read port and any stream consumer, such as a UART TX or a DMA sink.

---
 rtl/fifo_stream_reader.sv | 94 +++++++++
 tb/tb_fifo_stream_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a BUF_DEPTH-entry skid buffer, presented downstream as valid/ready; FIFO_READER_FWFT_EN selects a first-word-fall-through FIFO.
// Latency: a word reaches o_VALID 2 cycles after o_FIFO_RD_EN (1 cycle with FIFO_READER_FWFT_EN).
// Backpressure: o_FIFO_RD_EN is withheld while buffered plus in-flight words would exceed BUF_DEPTH.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                         i_CLK,
  input  logic                         i_RESET,
  input  logic                         i_FIFO_EMPTY,
  input  logic [WIDTH-1:0]             i_FIFO_RD_DATA,
  input  logic                         i_FIFO_VALID,
  output logic                         o_FIFO_RD_EN,
  output logic [WIDTH-1:0]             o_DATA,
  output logic                         o_VALID,
  input  logic                         i_READY,
  output logic [$clog2(BUF_DEPTH):0]   o_BUF_COUNT,
  output logic [CNT_W-1:0]             o_XFER_CNT,
  output logic                         o_PROTO_ERR
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int LVL_W = PTR_W + 2;

  logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] xfer_cnt;
  logic             pop;
  logic             push;
  logic [LVL_W-1:0] level;

  assign pop = (count != '0) & i_READY;

`ifdef FIFO_READER_FWFT_EN
  logic unused_fifo_valid;
  assign unused_fifo_valid = i_FIFO_VALID;

  // Read data is already on the bus, so the pop and the buffer write coincide.
  assign level       = LVL_W'(count) - LVL_W'(pop);
  assign push        = o_FIFO_RD_EN;
  assign o_PROTO_ERR = 1'b0;
`else
  logic inflight;
  logic proto_err;

  // An outstanding read already owns a buffer slot even though its data has not landed.
  assign level       = LVL_W'(count) + LVL_W'(inflight) - LVL_W'(pop);
  assign push        = i_FIFO_VALID & inflight;
  assign o_PROTO_ERR = proto_err;

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      inflight  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      inflight <= o_FIFO_RD_EN;
      if (i_FIFO_VALID != inflight) proto_err <= 1'b1;
    end
  end
`endif

  assign o_FIFO_RD_EN = !i_RESET & !i_FIFO_EMPTY & (level < LVL_W'(BUF_DEPTH));

  always_ff @(posedge i_CLK) begin
    if (push && !i_RESET) buf_mem[wr_ptr] <= i_FIFO_RD_DATA;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      xfer_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        xfer_cnt <= xfer_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_VALID     = (count != '0);
  assign o_DATA      = o_VALID ? buf_mem[rd_ptr] : '0;
  assign o_BUF_COUNT = count;
  assign o_XFER_CNT  = xfer_cnt;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT, a scoreboard checks order, occupancy and counters.
module tb_fifo_stream_reader;
  localparam int WIDTH = 8;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W = 16;
`ifdef FIFO_READER_FWFT_EN
  localparam bit FW = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit FW = 1'b0;
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_RESET;
  logic             i_FIFO_EMPTY;
  logic [WIDTH-1:0] i_FIFO_RD_DATA;
  logic             i_FIFO_VALID;
  logic             o_FIFO_RD_EN;
  logic [WIDTH-1:0] o_DATA;
  logic             o_VALID;
  logic             i_READY;
  logic [1:0]       o_BUF_COUNT;
  logic [CNT_W-1:0] o_XFER_CNT;
  logic             o_PROTO_ERR;

  fifo_stream_reader #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
    .i_CLK(clk), .i_RESET(i_RESET), .i_FIFO_EMPTY(i_FIFO_EMPTY),
    .i_FIFO_RD_DATA(i_FIFO_RD_DATA), .i_FIFO_VALID(i_FIFO_VALID),
    .o_FIFO_RD_EN(o_FIFO_RD_EN), .o_DATA(o_DATA), .o_VALID(o_VALID),
    .i_READY(i_READY), .o_BUF_COUNT(o_BUF_COUNT), .o_XFER_CNT(o_XFER_CNT),
    .o_PROTO_ERR(o_PROTO_ERR)
  );

  typedef struct {
    logic       rst;
    logic       empty;
    logic       ready;
    logic       exp_rd;
    logic       exp_v;
    logic [1:0] exp_c;
  } vec_t;
  vec_t tbl[15];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents, expected downstream order, words delivered and beats taken.
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int  arrived = 0;
  int  accepted = 0;
  int  cyc = 0;
  bit  exp_proto = 0;
  bit  hold_prev = 0;
  bit  legit_vld = 0;
  bit  spur_now = 0;
  bit  inject = 0;
  logic [7:0] prev_data = 8'h00;
  logic       s_rd_en, s_valid, s_proto;
  logic [1:0] s_cnt;
  logic [15:0] s_xfer;
  logic [7:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    i_FIFO_EMPTY = (fq.size() == 0);
    if (FW) i_FIFO_RD_DATA = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic load(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic tick();
    logic rd, rst;
    logic [31:0] want;
    @(negedge clk);
    s_rd_en = o_FIFO_RD_EN; s_valid = o_VALID; s_cnt = o_BUF_COUNT;
    s_xfer = o_XFER_CNT; s_data = o_DATA; s_proto = o_PROTO_ERR;
    rst = i_RESET;
    rd = o_FIFO_RD_EN;
    chk("rd_en_when_empty_or_reset", o_FIFO_RD_EN & (i_FIFO_EMPTY | i_RESET), 0);
    chk("buf_count", o_BUF_COUNT, arrived - accepted);
    chk("valid", o_VALID, arrived != accepted);
    chk("xfer_cnt", o_XFER_CNT, accepted % 65536);
    chk("proto_err", o_PROTO_ERR, exp_proto);
    if (!o_VALID) chk("data_idle_zero", o_DATA, 0);
    if (hold_prev) chk("data_hold", o_DATA, prev_data);
    if (o_VALID && i_READY) begin
      want = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
      chk("beat_data", o_DATA, want);
      accepted++;
    end
    hold_prev = o_VALID && !i_READY && !rst;
    prev_data = o_DATA;
    @(posedge clk);
    #1;
    cyc++;
    if (legit_vld) arrived++;
    if (spur_now) exp_proto = 1'b1;
    if (FW && rd && fq.size() != 0) begin
      void'(fq.pop_front());
      arrived++;
    end
    i_FIFO_VALID = 1'b0;
    legit_vld = 1'b0;
    spur_now = 1'b0;
    if (rst) begin
      // FIFO-side response and local words are dropped; the FIFO model keeps its backlog.
      arrived = 0; accepted = 0; exp_q = fq; exp_proto = 1'b0; hold_prev = 1'b0;
    end else if (!FW && rd && fq.size() != 0) begin
      i_FIFO_RD_DATA = fq.pop_front();
      i_FIFO_VALID = 1'b1;
      legit_vld = 1'b1;
    end else if (inject) begin
      i_FIFO_RD_DATA = 8'hEE;
      i_FIFO_VALID = 1'b1;
      spur_now = 1'b1;
      inject = 1'b0;
    end
    drive_fifo();
  endtask

  task automatic drain(input string name);
    i_READY = 1'b1;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || arrived != accepted); k++) tick();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t_rd, first_v, gaps;
    i_RESET = 1'b1; i_FIFO_EMPTY = 1'b1; i_FIFO_VALID = 1'b0;
    i_FIFO_RD_DATA = 8'h00; i_READY = 1'b0;

    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, FW, {1'b0, FW}};
    for (int i = 5; i < 15; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      i_RESET = tbl[i].rst; i_FIFO_EMPTY = tbl[i].empty; i_READY = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_en", i), o_FIFO_RD_EN, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_valid", i), o_VALID, tbl[i].exp_v);
      chk($sformatf("tbl%0d_count", i), o_BUF_COUNT, tbl[i].exp_c);
      chk($sformatf("tbl%0d_proto", i), o_PROTO_ERR, 0);
      @(posedge clk);
      #1;
    end

    // Reset held with a loaded FIFO, then a full 32-word stream.
    for (int i = 0; i < 32; i++) load(8'h1A + 8'(i));
    drive_fifo();
    i_READY = 1'b1;
    i_RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_rd_en", s_rd_en, 0);
      chk("rst_hold_valid", s_valid, 0);
    end
    i_RESET = 1'b0;
    tick();
    chk("first_rd_en_after_release", s_rd_en, 1);
    t_rd = cyc; first_v = -1; gaps = 0;
    for (int k = 0; k < 100 && accepted < 32; k++) begin
      tick();
      if (s_valid && first_v < 0) first_v = cyc;
      if (first_v >= 0 && !s_valid) gaps++;
    end
    chk("first_word_latency", first_v - t_rd, LAT);
    chk("stream_gaps", gaps, 0);
    chk("stream_beats", accepted, 32);
    tick();
    chk("stream_xfer_cnt", s_xfer, 32);
    chk("stream_rd_en_off", s_rd_en, 0);
    chk("stream_valid_off", s_valid, 0);

    // Backpressure mid-stream.
    for (int i = 0; i < 20; i++) load(8'h40 + 8'(i));
    drive_fifo();
    i_READY = 1'b1;
    repeat (5) tick();
    i_READY = 1'b0;
    repeat (6) tick();
    chk("bp_count_saturated", s_cnt, 2);
    chk("bp_rd_en_off", s_rd_en, 0);
    drain("bp_drained");

`ifndef FIFO_READER_FWFT_EN
    // Unsolicited read data: flagged, discarded, and the flag is sticky.
    inject = 1'b1;
    tick();
    tick();
    tick();
    chk("proto_set", s_proto, 1);
    chk("proto_word_dropped", s_valid, 0);
    for (int i = 0; i < 4; i++) load(8'h70 + 8'(i));
    drive_fifo();
    drain("proto_drained");
    tick();
    chk("proto_sticky", s_proto, 1);
`endif

    // Reset with a full local buffer.
    for (int i = 0; i < 10; i++) load(8'h80 + 8'(i));
    drive_fifo();
    i_READY = 1'b0;
    for (int k = 0; k < 10 && s_cnt != 2; k++) tick();
    chk("pre_reset_full", s_cnt, 2);
    i_RESET = 1'b1;
    tick();
    tick();
    chk("mid_rst_valid", s_valid, 0);
    chk("mid_rst_count", s_cnt, 0);
    chk("mid_rst_xfer", s_xfer, 0);
    chk("mid_rst_data", s_data, 0);
    chk("mid_rst_rd_en", s_rd_en, 0);
    i_RESET = 1'b0;
    drain("post_reset_drained");

    // Random traffic and random backpressure.
    for (int n = 0; n < 1500; n++) begin
      i_READY = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) begin
        int m;
        m = $urandom_range(3);
        for (int j = 0; j < m; j++) load(8'($urandom));
      end
      drive_fifo();
      tick();
    end
    drain("random_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
